// File: rtl/dbus_responder.sv
// dbus_responder: single-port data-bus responder backed by a word-addressed
// 64-bit store. Each request waits LATENCY cycles, then commits in one edge:
// it captures the old word for the response and merges the strobed bytes.
// A request whose valid drops before the commit edge is abandoned without
// side effects.
module dbus_responder #(
    parameter int DEPTH   = 512,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [63:0] req_addr,
    input  logic [2:0]  req_size,
    input  logic [7:0]  req_strobe,
    input  logic [63:0] req_data,
    output logic        resp_addr_ok,
    output logic        resp_data_ok,
    output logic [63:0] resp_data
);

    localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] LAT_CNT = 4'(LATENCY);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAITING,
        S_OVER
    } state_e;

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          resp_ok_q, resp_ok_d;
    logic [63:0]   resp_data_q, resp_data_d;

    // Request fields captured at acceptance; the commit uses these, not the
    // live inputs.
    logic [AW-1:0] index_q;
    logic [7:0]    strobe_q;
    logic [63:0]   wdata_q;

    logic          accept;
    logic          commit;

    // Backing store; deliberately not cleared by reset.
    logic [63:0]   mem_q [DEPTH];

    // Size code and the address bits outside the word index do not affect
    // the access.
    logic          unused_inputs;
    assign unused_inputs = ^{req_size, req_addr[63:3+AW], req_addr[2:0]};

    // Byte-lane merge: lanes with a set strobe take the new byte.
    function automatic logic [63:0] merge_bytes(
        input logic [63:0] old_word,
        input logic [63:0] new_word,
        input logic [7:0]  strobe
    );
        logic [63:0] merged;
        merged = old_word;
        for (int b = 0; b < 8; b++) begin
            if (strobe[b]) begin
                merged[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return merged;
    endfunction

    // Next-state, countdown and response decode.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        resp_ok_d   = 1'b0;
        resp_data_d = resp_data_q;
        accept      = 1'b0;
        commit      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    accept  = 1'b1;
                    cnt_d   = LAT_CNT;
                    state_d = S_WAITING;
                end
            end
            S_WAITING: begin
                if (!req_valid) begin
                    state_d = S_IDLE;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    commit      = 1'b1;
                    resp_ok_d   = 1'b1;
                    resp_data_d = mem_q[index_q];
                    state_d     = S_OVER;
                end
            end
            S_OVER: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control and response registers, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            resp_ok_q   <= 1'b0;
            resp_data_q <= 64'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            resp_ok_q   <= resp_ok_d;
            resp_data_q <= resp_data_d;
        end
    end

    // Capture the request fields when a request is accepted from IDLE.
    always_ff @(posedge clk) begin
        if (accept) begin
            index_q  <= req_addr[3 +: AW];
            strobe_q <= req_strobe;
            wdata_q  <= req_data;
        end
    end

    // Store update on the commit edge only.
    always_ff @(posedge clk) begin
        if (commit) begin
            mem_q[index_q] <= merge_bytes(mem_q[index_q], wdata_q, strobe_q);
        end
    end

    assign resp_addr_ok = resp_ok_q;
    assign resp_data_ok = resp_ok_q;
    assign resp_data    = resp_data_q;

endmodule

// File: tb/tb_dbus_responder.sv
// Bench for dbus_responder: a LATENCY=2/DEPTH=512 instance for directed and
// random traffic, and a LATENCY=0/DEPTH=16 instance for back-to-back reads.
module tb_dbus_responder;

    localparam int DEPTH  = 512;
    localparam int LAT    = 2;
    localparam int DEPTH0 = 16;

    logic        clk;
    logic        reset;

    logic        req_valid;
    logic [63:0] req_addr;
    logic [2:0]  req_size;
    logic [7:0]  req_strobe;
    logic [63:0] req_data;
    logic        resp_addr_ok;
    logic        resp_data_ok;
    logic [63:0] resp_data;

    logic        b_valid;
    logic [63:0] b_addr;
    logic [2:0]  b_size;
    logic [7:0]  b_strobe;
    logic [63:0] b_wdata;
    logic        b_addr_ok;
    logic        b_data_ok;
    logic [63:0] b_rdata;

    int          checks = 0;
    int          errors = 0;

    logic [63:0] mdl  [DEPTH];
    logic [63:0] mdl0 [DEPTH0];

    dbus_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_addr     (req_addr),
        .req_size     (req_size),
        .req_strobe   (req_strobe),
        .req_data     (req_data),
        .resp_addr_ok (resp_addr_ok),
        .resp_data_ok (resp_data_ok),
        .resp_data    (resp_data)
    );

    dbus_responder #(.DEPTH(DEPTH0), .LATENCY(0)) dut0 (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (b_valid),
        .req_addr     (b_addr),
        .req_size     (b_size),
        .req_strobe   (b_strobe),
        .req_data     (b_wdata),
        .resp_addr_ok (b_addr_ok),
        .resp_data_ok (b_data_ok),
        .resp_data    (b_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: strobed bytes take the new data, the rest keep the old word.
    function automatic logic [63:0] model_merge(input logic [63:0] old_w, input logic [63:0] new_w,
                                                input logic [7:0] s);
        logic [63:0] r;
        r = old_w;
        for (int b = 0; b < 8; b++) begin
            if (s[b]) r[8*b +: 8] = new_w[8*b +: 8];
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete access on dut; entered and left 1 time unit after an edge.
    task automatic transact(input logic [63:0] a, input logic [7:0] s, input logic [63:0] d,
                            input bit known, input bit scramble, output logic [63:0] rd);
        int          idx;
        int          n;
        bit          got;
        logic [63:0] exp_old;
        idx        = int'((a / 64'd8) % 64'(DEPTH));
        exp_old    = mdl[idx];
        req_valid  = 1'b1;
        req_addr   = a;
        req_strobe = s;
        req_data   = d;
        req_size   = 3'($urandom_range(0, 3));
        n   = 0;
        got = 1'b0;
        while (!got && n < 64) begin
            tick();
            n++;
            if (scramble && n == 1) begin
                req_addr   = a ^ 64'h8;
                req_strobe = ~s;
                req_data   = ~d;
            end
            got = resp_data_ok;
        end
        check("latency", 64'(n), 64'(LAT + 2));
        check("addr_ok_with_data_ok", {63'd0, resp_addr_ok}, 64'd1);
        if (known) check("rdata_old_word", resp_data, exp_old);
        rd       = resp_data;
        mdl[idx] = model_merge(exp_old, d, s);
        req_valid  = 1'b0;
        req_addr   = {$urandom, $urandom};
        req_strobe = 8'($urandom);
        req_data   = {$urandom, $urandom};
        tick();
        check("data_ok_one_cycle", {63'd0, resp_data_ok}, 64'd0);
        check("addr_ok_one_cycle", {63'd0, resp_addr_ok}, 64'd0);
        if (known) check("rdata_holds", resp_data, exp_old);
    endtask

    // Request that drops valid after k+1 cycles (k <= LAT), before the commit.
    task automatic abort_req(input logic [63:0] a, input logic [7:0] s, input logic [63:0] d,
                             input int k);
        logic seen;
        seen       = 1'b0;
        req_valid  = 1'b1;
        req_addr   = a;
        req_strobe = s;
        req_data   = d;
        repeat (k + 1) begin
            tick();
            seen = seen | resp_data_ok;
        end
        req_valid = 1'b0;
        repeat (LAT + 3) begin
            tick();
            seen = seen | resp_data_ok;
        end
        check("abort_no_data_ok", {63'd0, seen}, 64'd0);
    endtask

    // Full-word write into the LATENCY=0 instance.
    task automatic pre0(input int idx, input logic [63:0] v);
        int n;
        n        = 0;
        b_valid  = 1'b1;
        b_addr   = 64'(idx) * 64'd8;
        b_strobe = 8'hFF;
        b_wdata  = v;
        do begin
            tick();
            n++;
        end while (!b_data_ok && n < 64);
        check("pre0_done", {63'd0, b_data_ok}, 64'd1);
        b_valid   = 1'b0;
        mdl0[idx] = v;
        tick();
    endtask

    initial begin
        logic [63:0] rd;
        logic [63:0] v;
        logic [63:0] a;
        logic [63:0] old_w;
        logic [7:0]  s;
        logic [5:0]  exp_ok;
        int          i1;
        int          i2;

        reset      = 1'b0;
        req_valid  = 1'b0;
        req_addr   = 64'd0;
        req_size   = 3'd0;
        req_strobe = 8'd0;
        req_data   = 64'd0;
        b_valid    = 1'b0;
        b_addr     = 64'd0;
        b_size     = 3'd0;
        b_strobe   = 8'd0;
        b_wdata    = 64'd0;

        // Reset state holds before any clock edge.
        #1;
        check("reset_data_ok", {63'd0, resp_data_ok}, 64'd0);
        check("reset_addr_ok", {63'd0, resp_addr_ok}, 64'd0);
        check("reset_rdata", resp_data, 64'd0);
        repeat (3) tick();

        // Release reset; the very next edge accepts the first request.
        reset = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            v = (i == 4) ? 64'h1122334455667788 : {$urandom, $urandom};
            transact(64'(i) * 64'd8, 8'hFF, v, 1'b0, 1'b0, rd);
        end

        // Plain read of word 4.
        transact(64'h20, 8'h00, 64'd0, 1'b1, 1'b0, rd);
        check("read_preload", rd, 64'h1122334455667788);

        // Partial write returns the pre-write word; live inputs scrambled
        // after acceptance must not affect the commit.
        transact(64'h20, 8'h0F, 64'hAAAAAAAA_DEADBEEF, 1'b1, 1'b1, rd);
        check("write_returns_old", rd, 64'h1122334455667788);
        transact(64'h20, 8'h00, 64'd0, 1'b1, 1'b0, rd);
        check("partial_write_merge", rd, 64'h11223344DEADBEEF);

        // Abandoned full write leaves the word untouched.
        abort_req(64'h20, 8'hFF, 64'h0BAD0BAD0BAD0BAD, 1);
        transact(64'h20, 8'h00, 64'd0, 1'b1, 1'b0, rd);
        check("abort_no_write", rd, 64'h11223344DEADBEEF);

        // Index wrap: 0x1000 aliases word 0.
        transact(64'h1000, 8'hFF, 64'h5, 1'b1, 1'b0, rd);
        transact(64'h0, 8'h00, 64'd0, 1'b1, 1'b0, rd);
        check("index_wrap", rd, 64'h5);

        // Reset asserted mid-wait, away from the clock edge.
        a          = 64'h340;
        old_w      = mdl[int'((a / 64'd8) % 64'(DEPTH))];
        req_valid  = 1'b1;
        req_addr   = a;
        req_strobe = 8'hFF;
        req_data   = ~old_w;
        tick();
        tick();
        check("pre_reset_rdata_nonzero", {63'd0, (resp_data != 64'd0)}, 64'd1);
        #3;
        reset = 1'b0;
        #1;
        check("async_reset_data_ok", {63'd0, resp_data_ok}, 64'd0);
        check("async_reset_addr_ok", {63'd0, resp_addr_ok}, 64'd0);
        check("async_reset_rdata", resp_data, 64'd0);
        req_valid = 1'b0;
        tick();
        tick();
        check("in_reset_rdata", resp_data, 64'd0);
        reset = 1'b1;
        transact(a, 8'h00, 64'd0, 1'b1, 1'b0, rd);
        check("reset_blocks_write", rd, old_w);

        // Random traffic, including aliased addresses and aborted requests.
        for (int t = 0; t < 40; t++) begin
            a = {$urandom, $urandom};
            s = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
            v = {$urandom, $urandom};
            if ($urandom_range(0, 5) == 0) begin
                abort_req(a, s, v, $urandom_range(0, LAT));
            end else begin
                transact(a, s, v, 1'b1, 1'b0, rd);
            end
        end

        // LATENCY=0: two back-to-back reads, data_ok at C+2 and C+5.
        i1 = 3;
        i2 = 11;
        pre0(i1, {$urandom, $urandom});
        pre0(i2, {$urandom, $urandom});
        exp_ok   = 6'b010010;
        b_valid  = 1'b1;
        b_addr   = 64'(i1) * 64'd8;
        b_strobe = 8'h00;
        for (int k = 1; k <= 6; k++) begin
            tick();
            check("b2b_data_ok", {63'd0, b_data_ok}, {63'd0, exp_ok[6-k]});
            check("b2b_addr_ok", {63'd0, b_addr_ok}, {63'd0, exp_ok[6-k]});
            if (k == 2) begin
                check("b2b_rdata_first", b_rdata, mdl0[i1]);
                b_addr = 64'(i2) * 64'd8;
            end
            if (k == 3) check("b2b_rdata_hold", b_rdata, mdl0[i1]);
            if (k == 5) begin
                check("b2b_rdata_second", b_rdata, mdl0[i2]);
                b_valid = 1'b0;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
